// File: rtl/drain_exposure_sequencer.sv
// Frame/subframe sequencer that drives the modulation clock generator's drain, phase and duty
// selects and counts modulation periods on the generator's fed-back CLK_OUT_MODL.
module drain_exposure_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PHASE_W = 5,
  parameter int unsigned DUTY_W  = 4,
  parameter int unsigned IDX_W   = 4
) (
  input  logic               CLK_IN,
  input  logic               RST_B,
  input  logic               START,
  input  logic               ABORT,
  input  logic [IDX_W-1:0]   NUM_SUB,
  input  logic [CNT_W-1:0]   DRAIN_CYCLES,
  input  logic [CNT_W-1:0]   EXPO_PERIODS,
  input  logic [PHASE_W-1:0] PHASE_START,
  input  logic [PHASE_W-1:0] PHASE_STEP,
  input  logic [DUTY_W-1:0]  DUTY_CFG,
  input  logic               MODL_FB,
  output logic               DRAIN_B,
  output logic [PHASE_W-1:0] PHASE_SEL,
  output logic [DUTY_W-1:0]  DUTY_SEL,
  output logic [IDX_W-1:0]   SUB_IDX,
  output logic               BUSY,
  output logic               SUB_DONE,
  output logic               FRAME_DONE
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);

  typedef enum logic [1:0] {StIdle, StDrain, StExpose} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   drain_cnt_q;
  logic [CNT_W-1:0]   expo_cnt_q;
  logic [CNT_W-1:0]   drain_len_q;
  logic [CNT_W-1:0]   expo_len_q;
  logic [IDX_W-1:0]   num_sub_q;
  logic [PHASE_W-1:0] phase_step_q;
  logic               modl_q;

  logic               rise;
  logic [CNT_W-1:0]   drain_len_in;
  logic [CNT_W-1:0]   expo_len_in;

  // MODL_FB is already in the CLK_IN domain, so a single register is enough for edge detection.
  assign rise         = MODL_FB & ~modl_q;
  assign drain_len_in = (DRAIN_CYCLES == '0) ? CntOne : DRAIN_CYCLES;
  assign expo_len_in  = (EXPO_PERIODS == '0) ? CntOne : EXPO_PERIODS;

  always_ff @(posedge CLK_IN or negedge RST_B) begin
    if (!RST_B) begin
      state_q      <= StIdle;
      drain_cnt_q  <= '0;
      expo_cnt_q   <= '0;
      drain_len_q  <= '0;
      expo_len_q   <= '0;
      num_sub_q    <= '0;
      phase_step_q <= '0;
      modl_q       <= 1'b0;
      DRAIN_B      <= 1'b0;
      PHASE_SEL    <= '0;
      DUTY_SEL     <= '0;
      SUB_IDX      <= '0;
      BUSY         <= 1'b0;
      SUB_DONE     <= 1'b0;
      FRAME_DONE   <= 1'b0;
    end else begin
      modl_q     <= MODL_FB;
      SUB_DONE   <= 1'b0;
      FRAME_DONE <= 1'b0;

      if (ABORT) begin
        // Selects and index are left as they were so the generator sees no glitch on abort.
        state_q <= StIdle;
        DRAIN_B <= 1'b0;
        BUSY    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            DRAIN_B <= 1'b0;
            if (START) begin
              drain_len_q  <= drain_len_in;
              expo_len_q   <= expo_len_in;
              num_sub_q    <= NUM_SUB;
              phase_step_q <= PHASE_STEP;
              PHASE_SEL    <= PHASE_START;
              DUTY_SEL     <= DUTY_CFG;
              SUB_IDX      <= '0;
              BUSY         <= 1'b1;
              drain_cnt_q  <= drain_len_in;
              state_q      <= StDrain;
            end
          end

          StDrain: begin
            DRAIN_B     <= 1'b0;
            drain_cnt_q <= drain_cnt_q - CntOne;
            if (drain_cnt_q == CntOne) begin
              expo_cnt_q <= expo_len_q;
              DRAIN_B    <= 1'b1;
              state_q    <= StExpose;
            end
          end

          StExpose: begin
            if (rise) begin
              expo_cnt_q <= expo_cnt_q - CntOne;
              if (expo_cnt_q == CntOne) begin
                DRAIN_B  <= 1'b0;
                SUB_DONE <= 1'b1;
                if (SUB_IDX == num_sub_q) begin
                  FRAME_DONE <= 1'b1;
                  BUSY       <= 1'b0;
                  state_q    <= StIdle;
                end else begin
                  // Phase steps only while draining, so the generator never re-phases mid-exposure.
                  SUB_IDX     <= SUB_IDX + IdxOne;
                  PHASE_SEL   <= PHASE_SEL + phase_step_q;
                  drain_cnt_q <= drain_len_q;
                  state_q     <= StDrain;
                end
              end
            end
          end

          default: begin
            DRAIN_B <= 1'b0;
            BUSY    <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_drain_exposure_sequencer.sv
// Bench for drain_exposure_sequencer: builds the expected per-cycle output timeline of each frame
// from the drain/exposure timing rules and the MODL_FB waveform it drives, then compares every cycle.
module tb_drain_exposure_sequencer;

  localparam int CNT_W   = 16;
  localparam int PHASE_W = 5;
  localparam int DUTY_W  = 4;
  localparam int IDX_W   = 4;
  localparam int MAXE    = 4096;

  typedef struct packed {
    logic               db;
    logic               busy;
    logic               sd;
    logic               fd;
    logic [IDX_W-1:0]   idx;
    logic [PHASE_W-1:0] ph;
    logic [DUTY_W-1:0]  duty;
  } obs_t;

  logic               clk = 1'b0;
  logic               rst_b = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [IDX_W-1:0]   num_sub = '0;
  logic [CNT_W-1:0]   drain_cycles = '0;
  logic [CNT_W-1:0]   expo_periods = '0;
  logic [PHASE_W-1:0] phase_start = '0;
  logic [PHASE_W-1:0] phase_step = '0;
  logic [DUTY_W-1:0]  duty_cfg = '0;
  logic               modl_fb = 1'b0;
  logic               drain_b;
  logic [PHASE_W-1:0] phase_sel;
  logic [DUTY_W-1:0]  duty_sel;
  logic [IDX_W-1:0]   sub_idx;
  logic               busy;
  logic               sub_done;
  logic               frame_done;

  always #5 clk = ~clk;

  drain_exposure_sequencer #(
    .CNT_W  (CNT_W),
    .PHASE_W(PHASE_W),
    .DUTY_W (DUTY_W),
    .IDX_W  (IDX_W)
  ) dut (
    .CLK_IN      (clk),
    .RST_B       (rst_b),
    .START       (start),
    .ABORT       (abort),
    .NUM_SUB     (num_sub),
    .DRAIN_CYCLES(drain_cycles),
    .EXPO_PERIODS(expo_periods),
    .PHASE_START (phase_start),
    .PHASE_STEP  (phase_step),
    .DUTY_CFG    (duty_cfg),
    .MODL_FB     (modl_fb),
    .DRAIN_B     (drain_b),
    .PHASE_SEL   (phase_sel),
    .DUTY_SEL    (duty_sel),
    .SUB_IDX     (sub_idx),
    .BUSY        (busy),
    .SUB_DONE    (sub_done),
    .FRAME_DONE  (frame_done)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   frame_no = 0;
  logic m [MAXE];      // MODL_FB value sampled at frame-local edge i
  obs_t exp_q [MAXE];  // expected outputs just after frame-local edge i
  int   end_e;
  int   rel_of  [16];
  int   done_of [16];

  function automatic obs_t mk(input bit db, input bit bz, input bit sd, input bit fd,
                              input int idx, input int ph, input int duty);
    obs_t o;
    o.db   = db;
    o.busy = bz;
    o.sd   = sd;
    o.fd   = fd;
    o.idx  = IDX_W'(idx);
    o.ph   = PHASE_W'(ph);
    o.duty = DUTY_W'(duty);
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.db   = drain_b;
    o.busy = busy;
    o.sd   = sub_done;
    o.fd   = frame_done;
    o.idx  = sub_idx;
    o.ph   = phase_sel;
    o.duty = duty_sel;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed db/busy/sd/fd/idx/ph/duty=%b/%b/%b/%b/%0d/%0d/%0d expected %b/%b/%b/%b/%0d/%0d/%0d",
             tag, got.db, got.busy, got.sd, got.fd, got.idx, got.ph, got.duty,
             want.db, want.busy, want.sd, want.fd, want.idx, want.ph, want.duty);
    end
  endtask

  // Square wave with the given half period; optionally held high for the first hold_hi edges.
  task automatic gen_modl(input int half, input int ofs, input int hold_hi);
    for (int i = 0; i < MAXE; i++) begin
      m[i] = (i < hold_hi) ? 1'b1 : (((i + ofs) / half) % 2 == 1);
    end
  endtask

  // Timeline: drain of D edges from the subframe start, then count 0->1 transitions of MODL_FB
  // strictly after the release edge; the N-th one ends the subframe.
  task automatic build_model(input int ns, input int dc, input int ep, input int ps, input int st,
                             input int duty, input int ab);
    int d;
    int n;
    int t;
    int ph;
    int cnt;
    int e;
    d  = (dc == 0) ? 1 : dc;
    n  = (ep == 0) ? 1 : ep;
    t  = 0;
    ph = ps;
    for (int j = 0; j <= ns; j++) begin
      rel_of[j] = t + d;
      for (int k = t; k < rel_of[j]; k++) exp_q[k] = mk(0, 1, 0, 0, j, ph, duty);
      if (j > 0) exp_q[t].sd = 1'b1;
      cnt = 0;
      e   = rel_of[j];
      while (cnt < n) begin
        if (e >= MAXE - 2) begin
          $display("FAIL model_timeline: frame exceeds %0d cycles", MAXE);
          $fatal(1, "timeline overflow");
        end
        exp_q[e] = mk(1, 1, 0, 0, j, ph, duty);
        e++;
        if (m[e] && !m[e-1]) cnt++;
      end
      done_of[j] = e;
      if (j == ns) begin
        exp_q[e] = mk(0, 0, 1, 1, j, ph, duty);
        end_e    = e;
      end
      ph = (ph + st) % (1 << PHASE_W);
      t  = e;
    end
    if (ab >= 0) begin
      exp_q[ab] = mk(0, 0, 0, 0, exp_q[ab-1].idx, exp_q[ab-1].ph, duty);
      end_e     = ab;
    end
  endtask

  task automatic run_frame(input int ns, input int dc, input int ep, input int ps, input int st,
                           input int duty, input int ab, input bit noise, input int rst_e);
    obs_t hold;
    frame_no++;
    build_model(ns, dc, ep, ps, st, duty, ab);
    hold      = exp_q[end_e];
    hold.db   = 1'b0;
    hold.busy = 1'b0;
    hold.sd   = 1'b0;
    hold.fd   = 1'b0;
    num_sub      = IDX_W'(ns);
    drain_cycles = CNT_W'(dc);
    expo_periods = CNT_W'(ep);
    phase_start  = PHASE_W'(ps);
    phase_step   = PHASE_W'(st);
    duty_cfg     = DUTY_W'(duty);
    start        = 1'b1;
    abort        = 1'b0;
    modl_fb      = m[0];
    for (int e = 0; e <= end_e + 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("frame%0d_edge%0d", frame_no, e), observe(), (e <= end_e) ? exp_q[e] : hold);
      if (e == rst_e) begin
        #2 rst_b = 1'b0;
        #1 check($sformatf("frame%0d_async_reset", frame_no), observe(), '0);
        start   = 1'b0;
        abort   = 1'b0;
        modl_fb = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(posedge clk);
          @(negedge clk);
          check($sformatf("frame%0d_idle_after_reset%0d", frame_no, i), observe(), '0);
        end
        return;
      end
      start   = noise && (e + 1 <= end_e) && ($urandom_range(0, 3) == 0);
      abort   = (ab >= 0) && (e + 1 == ab);
      modl_fb = (e + 1 <= end_e) ? m[e+1] : 1'b0;
      if (noise) begin
        num_sub      = IDX_W'($urandom);
        drain_cycles = CNT_W'($urandom);
        expo_periods = CNT_W'($urandom);
        phase_start  = PHASE_W'($urandom);
        phase_step   = PHASE_W'($urandom);
        duty_cfg     = DUTY_W'($urandom);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int ab;
    int ns;
    int half;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", observe(), '0);
    rst_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("idle_no_start%0d", i), observe(), '0);
    end

    // Single subframe, 10-cycle modulation period.
    gen_modl(5, 0, 0);
    run_frame(0, 4, 2, 7, 0, 3, -1, 1'b0, -1);

    // Phase stepping with wrap: 28, 1, 6, 11.
    gen_modl(3, 1, 0);
    run_frame(3, 3, 2, 28, 5, 9, -1, 1'b0, -1);

    // Zero drain and exposure lengths.
    gen_modl(2, 0, 0);
    run_frame(1, 0, 0, 0, 2, 1, -1, 1'b0, -1);

    // Abort during the second subframe's exposure, then a clean full frame.
    gen_modl(2, 1, 0);
    build_model(3, 2, 3, 4, 3, 5, -1);
    ab = rel_of[1] + 1 + int'($urandom_range(0, done_of[1] - rel_of[1] - 1));
    run_frame(3, 2, 3, 4, 3, 5, ab, 1'b0, -1);
    run_frame(3, 2, 3, 4, 3, 5, -1, 1'b0, -1);

    // START and config noise while busy; MODL_FB held high across the first release.
    gen_modl(3, 0, 3 + 5);
    run_frame(2, 3, 2, 10, 7, 6, -1, 1'b1, -1);

    // Sixteen subframes, index must not wrap.
    gen_modl(2, 0, 0);
    run_frame(15, 2, 1, 31, 1, 12, -1, 1'b0, -1);

    // Asynchronous reset in the middle of an exposure.
    gen_modl(3, 0, 0);
    run_frame(2, 5, 6, 3, 4, 2, -1, 1'b0, 8);

    for (int r = 0; r < 10; r++) begin
      ns   = int'($urandom_range(0, 5));
      half = int'($urandom_range(1, 5));
      gen_modl(half, int'($urandom_range(0, 2 * half - 1)),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : 0);
      run_frame(ns, int'($urandom_range(0, 8)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 15)), -1, 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
